// File: rtl/conv2_pkg.sv
// Shared types, constants and sizing helpers for the conv2 layer sequencer.
package conv2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LAST   = 3'd2,
    COMMIT = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_e;

  localparam int NUM_TAPS = 9;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_IMAGE_SIZE    = 222;
  localparam int DEF_NUM_CHANNELS  = 64;
  localparam int DEF_DRAIN_TIMEOUT = 1024;

  // Sizing helpers so the top level derives every width from its own parameters.
  function automatic int calc_nw(input int num_channels);
    return num_channels * NUM_TAPS;
  endfunction

  function automatic int calc_pix(input int image_size);
    return image_size * image_size;
  endfunction

  function automatic int calc_out(input int image_size);
    return (image_size - 2) * (image_size - 2);
  endfunction

  localparam int NW            = calc_nw(DEF_NUM_CHANNELS);
  localparam int WADDR_W       = $clog2(NW);
  localparam int PIX_PER_FRAME = calc_pix(DEF_IMAGE_SIZE);
  localparam int OUT_PER_FRAME = calc_out(DEF_IMAGE_SIZE);
  localparam int PIX_CNT_W     = $clog2(PIX_PER_FRAME + 1);
  localparam int OUT_CNT_W     = $clog2(OUT_PER_FRAME + 1);
  localparam int TMO_CNT_W     = $clog2(DEF_DRAIN_TIMEOUT + 1);

endpackage

// File: rtl/conv2_weight_loader.sv
// Weight fetch path: read address generator, one-cycle delayed write
// address, and the shadow weight bank with one write enable per slot.
module conv2_weight_loader
  import conv2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NW         = 576,
  parameter int WADDR_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     rd_en_i,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  output logic [WADDR_W-1:0]       rd_addr_o,
  output logic                     issue_last_o,
  output logic [NW*DATA_WIDTH-1:0] bank_o
);

  logic [WADDR_W-1:0] addr_q;
  logic [WADDR_W-1:0] wr_addr_q;
  logic               wr_vld_q;

  assign rd_addr_o    = addr_q;
  assign issue_last_o = rd_en_i && (addr_q == WADDR_W'(NW - 1));

  // Read address: cleared on a new run, steps once per issued read, parks on the last index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
    end else if (clr_i) begin
      addr_q <= '0;
    end else if (rd_en_i && !issue_last_o) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // Read data returns one cycle after the strobe, so the slot index trails the read address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      wr_vld_q  <= rd_en_i;
      wr_addr_q <= addr_q;
    end
  end

  for (genvar i = 0; i < NW; i++) begin : g_slot
    logic                  slot_we;
    logic [DATA_WIDTH-1:0] slot_q;

    assign slot_we = wr_vld_q && (wr_addr_q == WADDR_W'(i));

    // Bank slot: holds its weight until the matching delayed address returns data again.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_q <= '0;
      end else if (slot_we) begin
        slot_q <= rd_data_i;
      end
    end

    assign bank_o[i*DATA_WIDTH +: DATA_WIDTH] = slot_q;
  end

endmodule

// File: rtl/conv2_layer_ctrl.sv
// Second conv layer sequencer: loads the kernel bank, admits one frame of
// pixel vectors, and counts summed outputs until the frame completes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; strobes low, bank holds last weights
//   LOAD_W | issuing weight reads 0..NW-1, one per cycle
//   LAST   | no read issued; final returned byte is written
//   COMMIT | bank complete; load_weight pulsed for this cycle only
//   STREAM | src_ready high; counting accepted pixel vectors
//   DRAIN  | src_ready low; waiting for all outputs or the timeout
//   DONE   | frame_done pulsed; frame_err qualifies it
module conv2_layer_ctrl
  import conv2_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int IMAGE_SIZE    = DEF_IMAGE_SIZE,
  parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  localparam int C_NW      = calc_nw(NUM_CHANNELS),
  localparam int C_WADDR_W = $clog2(C_NW),
  localparam int C_OUT     = calc_out(IMAGE_SIZE),
  localparam int C_OUT_W   = $clog2(C_OUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       wgt_rd_en,
  output logic [C_WADDR_W-1:0]       wgt_rd_addr,
  input  logic [DATA_WIDTH-1:0]      wgt_rd_data,
  output logic [C_NW*DATA_WIDTH-1:0] weights,
  output logic                       load_weight,
  input  logic                       src_valid,
  output logic                       src_ready,
  output logic                       pixel_valid,
  input  logic                       conv_out_valid,
  output logic                       frame_done,
  output logic                       frame_err,
  output logic [C_OUT_W-1:0]         out_count
);

  localparam int C_PIX   = calc_pix(IMAGE_SIZE);
  localparam int C_PIX_W = $clog2(C_PIX + 1);
  localparam int C_TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  state_e               state_q;
  logic                 busy_q;
  logic                 rd_en_q;
  logic                 load_q;
  logic                 ready_q;
  logic                 done_q;
  logic                 err_q;
  logic [C_PIX_W-1:0]   pix_cnt_q;
  logic [C_OUT_W-1:0]   out_cnt_q;
  logic [C_OUT_W-1:0]   out_cnt_d;
  logic [C_TMO_W-1:0]   tmo_q;

  logic                 start_ok;
  logic                 handshake;
  logic                 pix_last;
  logic                 out_en;
  logic                 out_full;
  logic                 rd_last;

  assign start_ok  = start && (state_q == IDLE);
  assign handshake = src_valid && ready_q;
  assign pix_last  = handshake && (pix_cnt_q == C_PIX_W'(C_PIX - 1));

  // Outputs count only while the datapath is live and saturate at a full frame.
  assign out_en    = conv_out_valid && ((state_q == STREAM) || (state_q == DRAIN))
                     && (out_cnt_q != C_OUT_W'(C_OUT));
  assign out_cnt_d = out_en ? (out_cnt_q + 1'b1) : out_cnt_q;
  // Looks at the post-increment count so an output arriving this cycle can end DRAIN now.
  assign out_full  = (out_cnt_d == C_OUT_W'(C_OUT));

  assign busy        = busy_q;
  assign wgt_rd_en   = rd_en_q;
  assign load_weight = load_q;
  assign src_ready   = ready_q;
  assign pixel_valid = handshake;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign out_count   = out_cnt_q;

  conv2_weight_loader #(
    .DATA_WIDTH (DATA_WIDTH),
    .NW         (C_NW),
    .WADDR_W    (C_WADDR_W)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start_ok),
    .rd_en_i      (rd_en_q),
    .rd_data_i    (wgt_rd_data),
    .rd_addr_o    (wgt_rd_addr),
    .issue_last_o (rd_last),
    .bank_o       (weights)
  );

  // Sequencer: next state, registered strobes, pixel counter and drain timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      load_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      pix_cnt_q <= '0;
      tmo_q     <= '0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD_W;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            err_q     <= 1'b0;
            pix_cnt_q <= '0;
          end
        end
        LOAD_W: begin
          if (rd_last) begin
            state_q <= LAST;
            rd_en_q <= 1'b0;
          end
        end
        LAST: begin
          state_q <= COMMIT;
          load_q  <= 1'b1;
        end
        COMMIT: begin
          state_q <= STREAM;
          ready_q <= 1'b1;
        end
        STREAM: begin
          if (handshake) begin
            pix_cnt_q <= pix_cnt_q + 1'b1;
            if (pix_last) begin
              state_q <= DRAIN;
              ready_q <= 1'b0;
              tmo_q   <= C_TMO_W'(DRAIN_TIMEOUT - 1);
            end
          end
        end
        DRAIN: begin
          if (out_full) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (tmo_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Output counter: cleared by an accepted start, otherwise follows the saturating increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_q <= '0;
    end else if (start_ok) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_conv2_layer_ctrl.sv
// Bench for conv2_layer_ctrl on a 6x6, 2-channel configuration.
module tb_conv2_layer_ctrl;

  localparam int DW   = 8;
  localparam int IS   = 6;
  localparam int CH   = 2;
  localparam int TMO  = 32;
  localparam int NW   = CH * 9;
  localparam int PIX  = IS * IS;
  localparam int OUTS = (IS - 2) * (IS - 2);
  localparam int AW   = $clog2(NW);
  localparam int OW   = $clog2(OUTS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             busy;
  logic             wgt_rd_en;
  logic [AW-1:0]    wgt_rd_addr;
  logic [DW-1:0]    wgt_rd_data = '0;
  logic [NW*DW-1:0] weights;
  logic             load_weight;
  logic             src_valid = 1'b0;
  logic             src_ready;
  logic             pixel_valid;
  logic             conv_out_valid = 1'b0;
  logic             frame_done;
  logic             frame_err;
  logic [OW-1:0]    out_count;

  always #5 clk = ~clk;

  conv2_layer_ctrl #(
    .DATA_WIDTH    (DW),
    .IMAGE_SIZE    (IS),
    .NUM_CHANNELS  (CH),
    .DRAIN_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .wgt_rd_en      (wgt_rd_en),
    .wgt_rd_addr    (wgt_rd_addr),
    .wgt_rd_data    (wgt_rd_data),
    .weights        (weights),
    .load_weight    (load_weight),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .pixel_valid    (pixel_valid),
    .conv_out_valid (conv_out_valid),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .out_count      (out_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  event tick;

  // Environment state shared by the monitor and the scenarios.
  int       sv_mode = 0;
  int       rom_key = 0;
  logic [DW-1:0] rom_pend = '0;
  int       rd_n = 0;
  int       rd_addr_log [64];
  int       rd_cyc_log  [64];
  int       acc = 0, p_idx = 0, hs_last_cyc = -10;
  int       out_limit = OUTS, outs_sent = 0, outs_seen = 0, last_out_cyc = -10;
  logic     pend_out = 1'b0, extra_out = 1'b0;
  int       lw_n = 0, lw_cyc = -1, fd_n = 0, fd_cyc = -1, fd_oc = -1;
  logic     fd_err = 1'b0;
  int       rdy_first_cyc = -1;
  logic     prev_rdy = 1'b0;
  logic     rdy_after_last = 1'b1;

  // Drives inputs just after each falling edge, samples outputs 1 ns later.
  // The ROM answers (addr+1)^key one cycle after a read; the datapath model
  // raises one output the cycle after each pixel that completes a 3x3 window.
  always @(negedge clk) begin
    cyc = cyc + 1;
    wgt_rd_data    = rom_pend;
    conv_out_valid = pend_out | extra_out;
    case (sv_mode)
      0:       src_valid = 1'b0;
      1:       src_valid = 1'b1;
      default: src_valid = 1'($urandom_range(0, 1));
    endcase
    #1;
    rom_pend = wgt_rd_en ? DW'((int'(wgt_rd_addr) + 1) ^ rom_key) : 8'hEE;
    if (wgt_rd_en && rd_n < 64) begin
      rd_addr_log[rd_n] = int'(wgt_rd_addr);
      rd_cyc_log[rd_n]  = cyc;
      rd_n = rd_n + 1;
    end
    if (load_weight) begin lw_n = lw_n + 1; lw_cyc = cyc; end
    if (src_ready && !prev_rdy && rdy_first_cyc < 0) rdy_first_cyc = cyc;
    prev_rdy = src_ready;
    if (acc == PIX && hs_last_cyc == cyc - 1) rdy_after_last = src_ready;
    pend_out = 1'b0;
    if (pixel_valid) begin
      p_idx = acc;
      acc = acc + 1;
      hs_last_cyc = cyc;
      if ((p_idx / IS) >= 2 && (p_idx % IS) >= 2 && outs_sent < out_limit) begin
        pend_out = 1'b1;
        outs_sent = outs_sent + 1;
      end
    end
    if (conv_out_valid && !extra_out) begin outs_seen = outs_seen + 1; last_out_cyc = cyc; end
    if (frame_done) begin
      fd_n = fd_n + 1; fd_cyc = cyc; fd_err = frame_err; fd_oc = int'(out_count);
    end
    -> tick;
  end

  task automatic step(input int n);
    repeat (n) @(tick);
  endtask

  task automatic begin_run(input int key, input int mode, input int lim, output int scyc);
    rom_key = key; sv_mode = mode; out_limit = lim;
    acc = 0; outs_sent = 0; outs_seen = 0; pend_out = 1'b0;
    rd_n = 0; lw_n = 0; fd_n = 0; lw_cyc = -1; fd_cyc = -1;
    hs_last_cyc = -10; last_out_cyc = -10; rdy_first_cyc = -1; rdy_after_last = 1'b1;
    start = 1'b1;
    scyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int k = 0;
    while (fd_n == 0 && k < 600) begin step(1); k++; end
    ok = (fd_n != 0);
  endtask

  task automatic wait_load(output bit ok);
    int k = 0;
    while (lw_n == 0 && k < 100) begin step(1); k++; end
    ok = (lw_n != 0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(3);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (wgt_rd_en !== 1'b0 || load_weight !== 1'b0 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: rd_en=%b load=%b done=%b expected all 0", wgt_rd_en, load_weight, frame_done); end
    n_cmp++; if (src_ready !== 1'b0 || pixel_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_ready: ready=%b pv=%b expected 0", src_ready, pixel_valid); end
    n_cmp++; if (frame_err !== 1'b0 || out_count !== '0 || wgt_rd_addr !== '0) begin
      n_err++; $display("FAIL reset_regs: err=%b cnt=%0d addr=%0d expected 0", frame_err, out_count, wgt_rd_addr); end
    n_cmp++; if (weights !== '0) begin n_err++; $display("FAIL reset_bank: got %h expected 0", weights); end
    rst = 1'b1;
    step(2);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_weight_load;
    int s, bad;
    bit ok;
    begin_run(0, 0, OUTS, s);
    wait_load(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wl_timeout: load_weight count %0d expected 1 within 100 cycles", lw_n); end
    step(3);
    n_cmp++; if (rd_n != NW) begin n_err++; $display("FAIL wl_read_count: got %0d expected %0d", rd_n, NW); end
    bad = 0;
    for (int i = 0; i < NW && i < rd_n; i++)
      if (rd_addr_log[i] != i || rd_cyc_log[i] != s + 1 + i) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wl_read_seq: %0d reads out of order/time, got %0d expected 0", bad, bad); end
    n_cmp++; if (lw_n != 1 || lw_cyc != s + 20) begin
      n_err++; $display("FAIL wl_pulse: count=%0d at offset %0d expected 1 at offset 20", lw_n, lw_cyc - s); end
    bad = 0;
    for (int i = 0; i < NW; i++) if (weights[i*DW +: DW] !== DW'(i + 1)) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL wl_bank: %0d bad slots, got %h", bad, weights); end
    n_cmp++; if (rdy_first_cyc != s + 21) begin
      n_err++; $display("FAIL wl_ready_rise: got offset %0d expected 21", rdy_first_cyc - s); end
    n_cmp++; if (busy !== 1'b1 || src_ready !== 1'b1) begin
      n_err++; $display("FAIL wl_stream: busy=%b ready=%b expected 1 1", busy, src_ready); end
  endtask

  task automatic test_stream_continuous;
    bit ok;
    sv_mode = 1;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL cont_timeout: frame_done count %0d expected 1", fd_n); end
    n_cmp++; if (acc != PIX) begin n_err++; $display("FAIL cont_accepts: got %0d expected %0d", acc, PIX); end
    n_cmp++; if (rdy_after_last !== 1'b0) begin n_err++; $display("FAIL cont_ready_drop: got %b expected 0", rdy_after_last); end
    n_cmp++; if (fd_err !== 1'b0 || fd_oc != OUTS) begin
      n_err++; $display("FAIL cont_result: err=%b out_count=%0d expected 0 %0d", fd_err, fd_oc, OUTS); end
    n_cmp++; if (fd_cyc != last_out_cyc + 1) begin
      n_err++; $display("FAIL cont_done_time: got %0d expected %0d", fd_cyc, last_out_cyc + 1); end
    step(4);
    n_cmp++; if (fd_n != 1 || busy !== 1'b0 || acc != PIX) begin
      n_err++; $display("FAIL cont_idle: done=%0d busy=%b acc=%0d expected 1 0 %0d", fd_n, busy, acc, PIX); end
  endtask

  task automatic test_timeout;
    int s;
    bit ok;
    begin_run(int'($urandom_range(0, 255)), 2, 10, s);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tmo_timeout: frame_done count %0d expected 1", fd_n); end
    n_cmp++; if (acc != PIX || outs_seen != 10) begin
      n_err++; $display("FAIL tmo_traffic: acc=%0d outs=%0d expected %0d 10", acc, outs_seen, PIX); end
    n_cmp++; if (fd_err !== 1'b1 || fd_oc != 10) begin
      n_err++; $display("FAIL tmo_result: err=%b out_count=%0d expected 1 10", fd_err, fd_oc); end
    n_cmp++; if (fd_cyc != hs_last_cyc + 1 + TMO) begin
      n_err++; $display("FAIL tmo_time: got %0d after drain entry expected %0d", fd_cyc - hs_last_cyc - 1, TMO); end
    step(2);
    extra_out = 1'b1;
    step(3);
    extra_out = 1'b0;
    step(1);
    n_cmp++; if (out_count !== OW'(10) || frame_err !== 1'b1) begin
      n_err++; $display("FAIL tmo_idle_hold: out_count=%0d err=%b expected 10 1", out_count, frame_err); end
  endtask

  task automatic test_stream_random;
    int s, k, bad, key;
    bit ok;
    key = int'($urandom_range(1, 255));
    begin_run(key, 2, OUTS, s);
    n_cmp++; if (frame_err !== 1'b0 || out_count !== '0) begin
      n_err++; $display("FAIL rnd_clear: err=%b out_count=%0d expected 0 0", frame_err, out_count); end
    k = 0;
    while (outs_seen < OUTS && k < 600) begin step(1); k++; end
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_cmp++; if (fd_n != 1) begin n_err++; $display("FAIL rnd_done: count %0d expected 1", fd_n); end
    n_cmp++; if (acc != PIX) begin n_err++; $display("FAIL rnd_accepts: got %0d expected %0d", acc, PIX); end
    n_cmp++; if (fd_err !== 1'b0 || fd_oc != OUTS || fd_cyc != last_out_cyc + 1) begin
      n_err++; $display("FAIL rnd_result: err=%b cnt=%0d lag=%0d expected 0 %0d 1", fd_err, fd_oc, fd_cyc - last_out_cyc, OUTS); end
    bad = 0;
    for (int i = 0; i < NW; i++) if (weights[i*DW +: DW] !== DW'((i + 1) ^ key)) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rnd_bank: %0d bad slots, got %h", bad, weights); end
    step(5);
    n_cmp++; if (busy !== 1'b0 || rd_n != NW) begin
      n_err++; $display("FAIL rnd_start_in_done: busy=%b reads=%0d expected 0 %0d", busy, rd_n, NW); end
  endtask

  task automatic test_reset_midrun;
    int s, k, bad, key;
    bit ok;
    begin_run(int'($urandom_range(0, 255)), 2, OUTS, s);
    k = 0;
    while (acc < 10 && k < 200) begin step(1); k++; end
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || src_ready !== 1'b0 || wgt_rd_en !== 1'b0 || load_weight !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_idle: busy=%b ready=%b rd=%b load=%b expected 0", busy, src_ready, wgt_rd_en, load_weight); end
    n_cmp++; if (weights !== '0) begin n_err++; $display("FAIL mid_reset_bank: got %h expected 0", weights); end
    step(2);
    rst = 1'b1;
    step(40);
    n_cmp++; if (fd_n != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_no_done: done=%0d busy=%b expected 0 0", fd_n, busy); end
    key = int'($urandom_range(0, 255));
    begin_run(key, 1, OUTS, s);
    step(4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_load(ok);
    n_cmp++; if (!ok || lw_n != 1 || lw_cyc != s + 20) begin
      n_err++; $display("FAIL mid_reload_pulse: count=%0d offset=%0d expected 1 20", lw_n, lw_cyc - s); end
    bad = 0;
    for (int i = 0; i < NW && i < rd_n; i++)
      if (rd_addr_log[i] != i || rd_cyc_log[i] != s + 1 + i) bad++;
    n_cmp++; if (rd_n != NW || bad != 0) begin
      n_err++; $display("FAIL mid_reload_reads: reads=%0d bad=%0d expected %0d 0", rd_n, bad, NW); end
    bad = 0;
    for (int i = 0; i < NW; i++) if (weights[i*DW +: DW] !== DW'((i + 1) ^ key)) bad++;
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL mid_reload_bank: %0d bad slots, got %h", bad, weights); end
    wait_done(ok);
    n_cmp++; if (!ok || acc != PIX || fd_err !== 1'b0 || fd_oc != OUTS) begin
      n_err++; $display("FAIL mid_rerun: done=%0d acc=%0d err=%b cnt=%0d expected 1 %0d 0 %0d", fd_n, acc, fd_err, fd_oc, PIX, OUTS); end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_stream_continuous();
    test_timeout();
    test_stream_random();
    test_reset_midrun();
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv2_layer_ctrl.md
# conv2_layer_ctrl

Sequencer for the 64-channel second convolution layer. It fetches the 576 kernel weights from an external weight memory into a shadow bank and pulses `load_weight` so the systolic array latches them. It then admits exactly one 222×222 frame of 64-channel pixel vectors from upstream and counts the 220×220 summed outputs until the frame completes. It sits between the first-layer output buffer / weight ROM and the conv datapath, and replaces the datapath's constant all-ones weight tie-off.

## Interface
- `DATA_WIDTH`, 8, bits per pixel and per weight
- `IMAGE_SIZE`, 222, input frame edge in pixels
- `NUM_CHANNELS`, 64, input channels; weight count `NW = NUM_CHANNELS*9`
- `DRAIN_TIMEOUT`, 1024, maximum cycles in DRAIN before aborting with error
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: pulse that begins one layer run; ignored while `busy`
- `busy` out 1: high in every state except IDLE
- `wgt_rd_en` out 1: weight memory read strobe
- `wgt_rd_addr` out `$clog2(NW)`: weight index, `c*9 + r*3 + k` (channel-major, row-major taps)
- `wgt_rd_data` in `DATA_WIDTH`: read data, valid exactly 1 cycle after `wgt_rd_en`
- `weights` out `NW*DATA_WIDTH`: shadow bank; index i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`
- `load_weight` out 1: one-cycle pulse once the bank is complete
- `src_valid` in 1 / `src_ready` out 1: upstream pixel-vector handshake
- `pixel_valid` out 1: `src_valid & src_ready`, drives the datapath
- `conv_out_valid` in 1: datapath output strobe
- `frame_done` out 1: one-cycle completion pulse
- `frame_err` out 1: qualifies `frame_done`; set on drain timeout
- `out_count` out `$clog2(OUT_PER_FRAME+1)`: outputs counted this run

## Operation
- Constants: `PIX_PER_FRAME = IMAGE_SIZE²` (49284), `OUT_PER_FRAME = (IMAGE_SIZE-2)²` (48400).
- **IDLE**: all strobes low. `start` → LOAD_W; clears addr, pixel count, `out_count`, and `frame_err`. `weights` retains its last contents.
- **LOAD_W**: `wgt_rd_en=1`; `wgt_rd_addr` steps 0..NW-1, one address per cycle. Each returned byte is written to bank slot addr-1, using the delayed address. After issuing NW-1 → LAST.
- **LAST**: `wgt_rd_en=0`; captures the final byte → COMMIT.
- **COMMIT**: `load_weight=1` for exactly this cycle → STREAM.
- **STREAM**: `src_ready=1`. Each handshake increments the pixel count. The handshake that brings the count to PIX_PER_FRAME is the last one accepted → DRAIN; `src_ready` is low from the next cycle.
- **DRAIN**: `src_ready=0`. Waits until `out_count == OUT_PER_FRAME` → DONE. If `DRAIN_TIMEOUT` cycles pass first, sets `frame_err` → DONE.
- **DONE**: `frame_done=1` for one cycle → IDLE. `frame_err` holds until the next `start`.
- `conv_out_valid` is counted only in STREAM and DRAIN and saturates at OUT_PER_FRAME. It is ignored in all other states.
- Pixel and output counters have no wrap-around; terminal compares use `==`.

## Timing
- Reset: state IDLE; all outputs 0, including the whole `weights` bank, `out_count`, and `frame_err`.
- `start` sampled high at edge T0:
  - `wgt_rd_en` is high in cycles T0+1..T0+NW.
  - LAST occurs at T0+NW+1.
  - `load_weight` is high at T0+NW+2.
  - `src_ready` first goes high at T0+NW+3.
- `weights` is stable from the `load_weight` cycle until the next LOAD_W.
- `src_ready` is registered from state. `pixel_valid` is combinational from it, with zero added latency.
- `src_valid` may stall arbitrarily; no pixel is dropped or duplicated.
- `conv_out_valid` in the same cycle as the DRAIN entry is counted.
- `start` asserted in the DONE cycle is ignored. `start` is accepted again from IDLE the following cycle.
- Asserting `rst` mid-run returns to IDLE asynchronously. The bank is cleared and no `frame_done` is issued.

## Structure
- Package `conv2_pkg`:
  - state enum: IDLE, LOAD_W, LAST, COMMIT, STREAM, DRAIN, DONE
  - `NUM_TAPS=9`
  - `NW`, `WADDR_W`, `PIX_PER_FRAME`, `OUT_PER_FRAME`, and counter widths, each derived from the parameters
- Sub-module `conv2_weight_loader`: address generator, delayed-address register, and shadow bank with per-slot write enable. The top level holds the FSM, frame counters, and timeout counter.

## Test plan
Scenarios run with `IMAGE_SIZE=6`, `NUM_CHANNELS=2`, so `NW=18`, `PIX_PER_FRAME=36`, and `OUT_PER_FRAME=16`.
- Weight ROM returns `addr+1`; pulse `start` → 18 reads at addresses 0..17; slot i = i+1; `load_weight` single pulse exactly 20 cycles after the `start` edge.
- Continuous `src_valid`, and the model raises `conv_out_valid` 16 times → exactly 36 `pixel_valid`; `src_ready` low after the 36th; `frame_done=1`, `frame_err=0`, `out_count=16`.
- Random `src_valid` gaps (~50% duty) → still 36 accepts, none lost; `frame_done` follows the 16th output by 1 cycle (DONE entered the cycle after the compare).
- Only 10 outputs delivered, `DRAIN_TIMEOUT=32` → `frame_done=1`, `frame_err=1`, `out_count=10`, 32 cycles after DRAIN entry.
- Reset asserted mid-STREAM, then `start` pulsed during LOAD_W → immediate IDLE with bank zeroed and no `frame_done`; the second `start` is ignored, and the run completes normally after a fresh `start`.
